dial_tracker: RTL
=================

DIAL_TRACKER -- requirements
Module: dial_tracker

Interface
REQ-001 Parameter MOD, default 100, dial modulus (positions 0..MOD-1), legal range 2..1024.
REQ-002 Parameter INIT, default 50, reset position, SHALL satisfy INIT < MOD.
REQ-003 Parameter MAG_W, default 10, command magnitude width.
REQ-004 Parameter CNT_W, default 16, event counter width.
REQ-005 Localparam POS_W = $clog2(MOD), position width.
REQ-006 clk  in  1  sole clock, all state updates on rising edge.
REQ-007 rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-008 in_valid  in  1  command offered.
REQ-009 in_ready  out  1  block can accept a command.
REQ-010 dir  in  1  0 = add (clockwise), 1 = subtract; sampled on accept.
REQ-011 mag  in  MAG_W  unsigned step count; sampled on accept.
REQ-012 clr_cnt  in  1  synchronous clear of both counters.
REQ-013 pos  out  POS_W  current dial position, registered.
REQ-014 land_cnt  out  CNT_W  commands ending at position 0.
REQ-015 pass_cnt  out  CNT_W  times the dial reached position 0 during movement.
REQ-016 busy  out  1  command in progress.
REQ-017 done  out  1  one-cycle pulse when a command's results are visible.

Function
REQ-018 FSM states IDLE and REDUCE; in_ready = (state==IDLE) && !rst; busy = (state==REDUCE).
REQ-019 Accept on rising edge with in_valid && in_ready: latch dir, rem <= mag, go REDUCE.
REQ-020 REDUCE, rem >= MOD: rem <= rem - MOD, pass_cnt += 1, stay in REDUCE.
REQ-021 REDUCE, rem < MOD: apply partial step r = rem, update pos and counters, go IDLE, assert done for the following cycle.
REQ-022 Latency: pos valid floor(mag/MOD)+1 edges after accept edge; next command accepted no earlier than the edge after that.
REQ-023 Add partial: s = pos + r; if s >= MOD then pos <= s - MOD and pass_cnt += 1, else pos <= s.
REQ-024 Subtract partial: if r <= pos, pos <= pos - r; else pos <= pos + MOD - r; pass_cnt += 1 iff pos != 0 && r >= pos.
REQ-025 Starting at 0 with partial r > 0 SHALL NOT count a pass; mag = 0 leaves pos unchanged and adds no pass.
REQ-026 land_cnt += 1 on completion iff final pos == 0, including mag = 0 at position 0.
REQ-027 Arithmetic SHALL use at least POS_W+1 bits; no intermediate value negative or truncated.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-029 clr_cnt zeroes both counters next edge, with priority over a same-cycle increment; pos and FSM unaffected.
REQ-030 in_valid while busy is ignored; the command is not queued.

Reset
REQ-031 On rst: pos = INIT, land_cnt = 0, pass_cnt = 0, rem = 0, state IDLE, done = 0.
REQ-032 rst during REDUCE aborts the command: no done, no partial counter update; in_ready high the first cycle rst is low.

Structure
REQ-033 Shared package dial_pkg SHALL hold FSM state encodings and default MOD/INIT constants.
REQ-034 Partial-step arithmetic (REQ-023..025) SHALL be a combinational sub-module dial_step (inputs pos, r, dir; outputs next pos, pass flag).
REQ-035 Target 120-400 lines of RTL total; no multipliers or dividers; modulo by iterative subtraction only.

Verification (MOD=100, INIT=50, CNT_W=16 unless stated)
REQ-036 Release rst -> pos=50, counters 0, in_ready=1, busy=0, done=0.
REQ-037 Sub 68 from 50 -> pos=82, pass_cnt=1, land_cnt=0, done 1 edge after accept; then add 30 -> pos=12, pass_cnt=2.
REQ-038 Add 50 from 50 -> pos=0, pass_cnt=1, land_cnt=1; then sub 5 -> pos=95, pass_cnt=1 (no pass from 0).
REQ-039 Add 1000 from 50 -> pos=50, pass_cnt=10, land_cnt=0, busy for 11 cycles, in_valid pulses while busy ignored.
REQ-040 Sub 1000 accepted, rst asserted 3 cycles later -> pos=50, counters 0, no done pulse.
REQ-041 CNT_W=4, sixteen add-100 commands from 0 -> land_cnt=15, pass_cnt=15 (saturated); clr_cnt with completion same cycle -> both 0.

Source files
------------

// File: rtl/dial_pkg.sv
// dial_pkg -- shared definitions for the dial tracker.
//   Default dial geometry (modulus and reset position) and the FSM state
//   encodings used by dial_tracker.
package dial_pkg;

   localparam int DIAL_MOD_DEFAULT  = 100;
   localparam int DIAL_INIT_DEFAULT = 50;

   // Two-state controller: waiting for a command, or stripping whole turns.
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_REDUCE = 1'b1;

endpackage

// File: rtl/dial_step.sv
// dial_step -- combinational partial move of the dial by r < MOD steps.
//   Ports:
//     pos      in   current position (0..MOD-1)
//     r        in   partial step count (0..MOD-1)
//     dir      in   0 = add (clockwise), 1 = subtract
//     next_pos out  position after the move
//     pass     out  the move reached position 0 (starting at 0 never counts)
module dial_step
   import dial_pkg::*;
#(
   parameter int  MOD   = DIAL_MOD_DEFAULT,
   localparam int POS_W = $clog2(MOD)
) (
   input  logic [POS_W-1:0] pos,
   input  logic [POS_W-1:0] r,
   input  logic             dir,
   output logic [POS_W-1:0] next_pos,
   output logic             pass
);

   // One extra bit holds pos + r and pos + MOD without overflow.
   localparam logic [POS_W:0] MOD_C = (POS_W+1)'(MOD);

   logic [POS_W:0] w_pos_ext;
   logic [POS_W:0] w_r_ext;
   logic [POS_W:0] w_sum;

   assign w_pos_ext = {1'b0, pos};
   assign w_r_ext   = {1'b0, r};
   assign w_sum     = w_pos_ext + w_r_ext;

   always_comb begin
      next_pos = pos;
      pass     = 1'b0;
      if (!dir) begin
         if (w_sum >= MOD_C) begin
            next_pos = POS_W'(w_sum - MOD_C);
            pass     = 1'b1;
         end else begin
            next_pos = w_sum[POS_W-1:0];
         end
      end else begin
         // Wrap by adding MOD first so the subtraction never goes negative.
         if (w_r_ext <= w_pos_ext) begin
            next_pos = POS_W'(w_pos_ext - w_r_ext);
         end else begin
            next_pos = POS_W'(w_pos_ext + MOD_C - w_r_ext);
         end
         pass = (pos != '0) && (w_r_ext >= w_pos_ext);
      end
   end

endmodule

// File: rtl/dial_tracker.sv
// dial_tracker -- tracks a circular dial driven by add/subtract commands and
//   counts how often it lands on, and passes through, position 0.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     in_valid/ready  command handshake; dir and mag sampled on accept
//     dir             0 = add, 1 = subtract
//     mag             unsigned step count
//     clr_cnt         clear both counters (wins over a same-cycle increment)
//     pos             current position (registered)
//     land_cnt        commands that finished at position 0 (saturating)
//     pass_cnt        times position 0 was reached while moving (saturating)
//     busy            command in progress
//     done            one-cycle pulse once a command's results are visible
module dial_tracker
   import dial_pkg::*;
#(
   parameter int  MOD   = DIAL_MOD_DEFAULT,
   parameter int  INIT  = DIAL_INIT_DEFAULT,
   parameter int  MAG_W = 10,
   parameter int  CNT_W = 16,
   localparam int POS_W = $clog2(MOD)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             dir,
   input  logic [MAG_W-1:0] mag,
   input  logic             clr_cnt,
   output logic [POS_W-1:0] pos,
   output logic [CNT_W-1:0] land_cnt,
   output logic [CNT_W-1:0] pass_cnt,
   output logic             busy,
   output logic             done
);

   // Compare width covers both the magnitude and MOD (which may need POS_W+1 bits).
   localparam int               CMP_W   = ((MAG_W > POS_W) ? MAG_W : POS_W) + 2;
   localparam logic [CMP_W-1:0] MOD_C   = CMP_W'(MOD);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [0:0]       r_state;
   logic             r_dir;
   logic [MAG_W-1:0] r_rem;
   logic [POS_W-1:0] r_pos;
   logic             r_done;

   logic [CMP_W-1:0] w_rem_ext;
   logic             w_rem_ge_mod;
   logic [POS_W-1:0] w_r;
   logic [POS_W-1:0] w_step_pos;
   logic             w_step_pass;
   logic             w_busy;
   logic             w_accept;
   logic             w_final;
   logic [1:0]       w_cnt_inc;

   assign w_rem_ext    = CMP_W'(r_rem);
   assign w_rem_ge_mod = (w_rem_ext >= MOD_C);
   // Only consumed once rem < MOD, so the low POS_W bits hold all of it.
   assign w_r          = w_rem_ext[POS_W-1:0];

   assign w_busy   = (r_state == ST_REDUCE);
   assign in_ready = (r_state == ST_IDLE) && !rst;
   assign w_accept = in_valid && in_ready;
   assign w_final  = w_busy && !w_rem_ge_mod;

   dial_step #(
      .MOD      (MOD)
   ) u_step (
      .pos      (r_pos),
      .r        (w_r),
      .dir      (r_dir),
      .next_pos (w_step_pos),
      .pass     (w_step_pass)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_dir   <= 1'b0;
         r_rem   <= '0;
         r_pos   <= POS_W'(INIT);
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_dir   <= dir;
                  r_rem   <= mag;
                  r_state <= ST_REDUCE;
               end
            end
            ST_REDUCE: begin
               if (w_rem_ge_mod) begin
                  // A whole turn always crosses 0 exactly once.
                  r_rem <= MAG_W'(w_rem_ext - MOD_C);
               end else begin
                  r_pos   <= w_step_pos;
                  r_rem   <= '0;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Index 0 = land counter, index 1 = pass counter.
   assign w_cnt_inc[0] = w_final && (w_step_pos == '0);
   assign w_cnt_inc[1] = (w_busy && w_rem_ge_mod) || (w_final && w_step_pass);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_W-1:0] r_cnt;
         always_ff @(posedge clk) begin
            if (rst || clr_cnt) begin
               r_cnt <= '0;
            end else if (w_cnt_inc[gi] && (r_cnt != CNT_MAX)) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   endgenerate

   assign pos      = r_pos;
   assign land_cnt = g_cnt[0].r_cnt;
   assign pass_cnt = g_cnt[1].r_cnt;
   assign busy     = w_busy;
   assign done     = r_done;

endmodule
